// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus types for the decoder and its slaves.
//   Z80MasterBus : CPU-driven address, write data and active-low strobes.
//   Z80SlaveBus  : slave read data plus mwait (1 = ready, 0 = stretch).
//   bus_sel_t    : which slave (or pseudo-slave) owns the current cycle.
//   dec_state_t  : decoder FSM states.
//   OPEN_BUS     : value seen on an undriven data bus.
package z80_bus_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        mreq_n;
        logic        iorq_n;
        logic        rd_n;
        logic        wr_n;
        logic        m1_n;
    } Z80MasterBus;

    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } Z80SlaveBus;

    typedef enum logic [2:0] {
        SEL_ROM,
        SEL_RAM,
        SEL_IO,
        SEL_INTACK,
        SEL_NONE
    } bus_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } dec_state_t;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/z80_wait_counter.sv
// Wait-state down-counter for the bus decoder.
//   clk, rst_n  : clock, synchronous active-low reset (count clears to 0)
//   i_load      : load i_load_val this cycle (takes priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one, saturating at 0
//   o_last      : count currently equals 1 (last wait cycle)
module z80_wait_counter #(
    parameter int unsigned WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_last
);

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WAIT_W'(1);
        end
    end

    assign o_last = (r_cnt == WAIT_W'(1));

endmodule

// File: rtl/z80_bus_decoder.sv
// Z80 bus decoder: classifies each CPU cycle, enables one slave, inserts
// per-slave wait states and muxes the selected slave's read data back.
//   clk, rst_n          : clock, synchronous active-low reset
//   cpu_bus             : CPU master bus (address, data, strobes)
//   cpu_resp            : read data and mwait returned to the CPU
//   rom_ena / rom_resp  : ROM enable and response
//   ram_ena / ram_resp  : RAM enable and response
//   io_ena  / io_resp   : I/O block enable and response
// Every *_WAIT parameter must be below 2**WAIT_W.
//
// state | meaning
// IDLE  | no access in flight; decode is live, an access starts here
// WAIT  | counting down inserted wait cycles, mwait held low
// HOLD  | data phase; held until strobes release and the slave is ready
module z80_bus_decoder
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] ROM_END     = 16'h7FFF,
    parameter logic [15:0] RAM_BASE    = 16'h8000,
    parameter logic [15:0] RAM_END     = 16'hFFFF,
    parameter int unsigned ROM_WAIT    = 1,
    parameter int unsigned RAM_WAIT    = 0,
    parameter int unsigned IO_WAIT     = 0,
    parameter logic [7:0]  INTACK_DATA = 8'hFF,
    parameter int unsigned WAIT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  Z80MasterBus cpu_bus,
    output Z80SlaveBus  cpu_resp,
    output logic        rom_ena,
    input  Z80SlaveBus  rom_resp,
    output logic        ram_ena,
    input  Z80SlaveBus  ram_resp,
    output logic        io_ena,
    input  Z80SlaveBus  io_resp
);

    localparam logic [WAIT_W-1:0] ROM_WV = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_WV = WAIT_W'(RAM_WAIT);
    localparam logic [WAIT_W-1:0] IO_WV  = WAIT_W'(IO_WAIT);

    dec_state_t        r_state;
    dec_state_t        w_state_nxt;
    bus_sel_t          r_sel;
    bus_sel_t          w_dec_sel;
    bus_sel_t          w_eff_sel;
    logic              w_rw;
    logic              w_mem;
    logic              w_io;
    logic              w_intack;
    logic              w_access;
    logic              w_in_rom;
    logic              w_in_ram;
    logic [WAIT_W-1:0] w_dec_wait;
    logic [WAIT_W-1:0] w_load_val;
    logic              w_start;
    logic              w_dec;
    logic              w_active;
    logic              w_mwait;
    logic              w_slave_mwait;
    logic              w_cnt_last;
    logic [7:0]        w_dslave;
    logic              w_unused_dmaster;

    // Write data goes straight to the slaves at top level.
    assign w_unused_dmaster = ^cpu_bus.dmaster;

    assign w_rw     = !cpu_bus.rd_n || !cpu_bus.wr_n;
    assign w_mem    = !cpu_bus.mreq_n && w_rw;
    assign w_io     = !cpu_bus.iorq_n && cpu_bus.m1_n && w_rw;
    assign w_intack = !cpu_bus.iorq_n && !cpu_bus.m1_n;
    assign w_access = w_mem || w_io || w_intack;

    // 17-bit compares keep the region checks non-constant when a bound
    // sits at the top of the address space.
    assign w_in_rom = ({1'b0, cpu_bus.addr} <= {1'b0, ROM_END});
    assign w_in_ram = ({1'b0, cpu_bus.addr} >= {1'b0, RAM_BASE}) &&
                      ({1'b0, cpu_bus.addr} <= {1'b0, RAM_END});

    always_comb begin
        w_dec_sel = SEL_NONE;
        if (w_intack) begin
            w_dec_sel = SEL_INTACK;
        end else if (w_io) begin
            w_dec_sel = SEL_IO;
        end else if (w_mem) begin
            if (w_in_rom) begin
                // ROM writes are swallowed: no enable, no wait.
                w_dec_sel = !cpu_bus.rd_n ? SEL_ROM : SEL_NONE;
            end else if (w_in_ram) begin
                w_dec_sel = SEL_RAM;
            end
        end
    end

    always_comb begin
        case (w_dec_sel)
            SEL_ROM: w_dec_wait = ROM_WV;
            SEL_RAM: w_dec_wait = RAM_WV;
            SEL_IO:  w_dec_wait = IO_WV;
            default: w_dec_wait = '0;
        endcase
    end

    // The start cycle already counts as the first wait cycle, so the
    // counter holds the number of WAIT-state cycles still to come.
    assign w_load_val = (w_dec_wait == '0) ? '0 : (w_dec_wait - WAIT_W'(1));

    z80_wait_counter #(
        .WAIT_W     (WAIT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_last     (w_cnt_last)
    );

    always_comb begin
        case (r_sel)
            SEL_ROM: w_slave_mwait = rom_resp.mwait;
            SEL_RAM: w_slave_mwait = ram_resp.mwait;
            SEL_IO:  w_slave_mwait = io_resp.mwait;
            default: w_slave_mwait = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_sel <= w_dec_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_dec       = 1'b0;
        w_active    = 1'b0;
        w_eff_sel   = SEL_NONE;
        w_mwait     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_start   = 1'b1;
                    w_active  = 1'b1;
                    w_eff_sel = w_dec_sel;
                    if (w_dec_wait != '0) begin
                        w_mwait = 1'b0;
                    end
                    w_state_nxt = (w_dec_wait > WAIT_W'(1)) ? ST_WAIT : ST_HOLD;
                end
            end
            ST_WAIT: begin
                w_active  = 1'b1;
                w_eff_sel = r_sel;
                w_mwait   = 1'b0;
                w_dec     = 1'b1;
                if (w_cnt_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_active  = 1'b1;
                w_eff_sel = r_sel;
                if (!w_slave_mwait) begin
                    w_mwait = 1'b0;
                end else if (cpu_bus.mreq_n && cpu_bus.iorq_n) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_dslave = OPEN_BUS;
        if (rst_n && w_active) begin
            case (w_eff_sel)
                SEL_ROM:    w_dslave = rom_resp.dslave;
                SEL_RAM:    w_dslave = ram_resp.dslave;
                SEL_IO:     w_dslave = io_resp.dslave;
                SEL_INTACK: w_dslave = INTACK_DATA;
                default:    w_dslave = OPEN_BUS;
            endcase
        end
    end

    // Outputs are forced idle while reset is held so a live CPU cycle
    // cannot leak an enable through the IDLE decode.
    assign rom_ena         = rst_n && w_active && (w_eff_sel == SEL_ROM);
    assign ram_ena         = rst_n && w_active && (w_eff_sel == SEL_RAM);
    assign io_ena          = rst_n && w_active && (w_eff_sel == SEL_IO);
    assign cpu_resp.dslave = w_dslave;
    assign cpu_resp.mwait  = w_mwait || !rst_n;

endmodule

// File: tb/tb_z80_bus_decoder.sv
module tb_z80_bus_decoder;
    import z80_bus_pkg::*;

    localparam logic [15:0] P_ROM_END  = 16'h3FFF;
    localparam logic [15:0] P_RAM_BASE = 16'h8000;
    localparam logic [15:0] P_RAM_END  = 16'hFFFF;
    localparam int          P_ROM_WAIT = 1;
    localparam int          P_RAM_WAIT = 0;
    localparam int          P_IO_WAIT  = 3;
    localparam logic [7:0]  P_INTACK   = 8'hFF;

    // model select codes
    localparam int S_ROM = 0, S_RAM = 1, S_IO = 2, S_INTACK = 3, S_NONE = 4, S_NOACC = 5;
    // transaction kinds
    localparam int K_MEMRD = 0, K_MEMWR = 1, K_IORD = 2, K_IOWR = 3, K_INTACK = 4, K_REFRESH = 5;
    localparam logic [11:0] IDLE_VEC = 12'h1FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    Z80MasterBus cpu_bus;
    Z80SlaveBus  cpu_resp;
    Z80SlaveBus  rom_resp, ram_resp, io_resp;
    logic        rom_ena, ram_ena, io_ena;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  d_rom, d_ram, d_io;
    logic [11:0] obs [64];

    always #5 clk = ~clk;

    z80_bus_decoder #(
        .ROM_END     (P_ROM_END),
        .RAM_BASE    (P_RAM_BASE),
        .RAM_END     (P_RAM_END),
        .ROM_WAIT    (P_ROM_WAIT),
        .RAM_WAIT    (P_RAM_WAIT),
        .IO_WAIT     (P_IO_WAIT),
        .INTACK_DATA (P_INTACK),
        .WAIT_W      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_bus  (cpu_bus),
        .cpu_resp (cpu_resp),
        .rom_ena  (rom_ena),
        .rom_resp (rom_resp),
        .ram_ena  (ram_ena),
        .ram_resp (ram_resp),
        .io_ena   (io_ena),
        .io_resp  (io_resp)
    );

    // ---------------- reference model ----------------
    function automatic int model_sel(input int k, input logic [15:0] a);
        int ai;
        ai = int'(a);
        case (k)
            K_MEMRD: begin
                if (ai <= int'(P_ROM_END)) return S_ROM;
                if (ai >= int'(P_RAM_BASE) && ai <= int'(P_RAM_END)) return S_RAM;
                return S_NONE;
            end
            K_MEMWR: begin
                if (ai <= int'(P_ROM_END)) return S_NONE;
                if (ai >= int'(P_RAM_BASE) && ai <= int'(P_RAM_END)) return S_RAM;
                return S_NONE;
            end
            K_IORD, K_IOWR: return S_IO;
            K_INTACK:       return S_INTACK;
            default:        return S_NOACC;
        endcase
    endfunction

    function automatic int model_wait(input int sel);
        case (sel)
            S_ROM:   return P_ROM_WAIT;
            S_RAM:   return P_RAM_WAIT;
            S_IO:    return P_IO_WAIT;
            default: return 0;
        endcase
    endfunction

    // First cycle in which a slave's own mwait can stretch the access.
    function automatic int model_hold_start(input int sel);
        return (model_wait(sel) == 0) ? 1 : model_wait(sel);
    endfunction

    // Expected {rom_ena, ram_ena, io_ena, mwait, dslave} in cycle k of an
    // access whose strobes are low for cycles 0..len-1.
    function automatic logic [11:0] model_vec(input int sel, input int k, input int len, input int ext);
        int n, hs, e;
        logic [2:0] en;
        logic       mw;
        logic [7:0] ds;
        if (sel == S_NOACC || k > len) return IDLE_VEC;
        n  = model_wait(sel);
        hs = model_hold_start(sel);
        e  = (sel <= S_IO) ? ext : 0;
        mw = !((k < n) || (k >= hs && k < hs + e));
        en = (sel == S_ROM) ? 3'b100 : (sel == S_RAM) ? 3'b010 : (sel == S_IO) ? 3'b001 : 3'b000;
        case (sel)
            S_ROM:    ds = d_rom;
            S_RAM:    ds = d_ram;
            S_IO:     ds = d_io;
            S_INTACK: ds = P_INTACK;
            default:  ds = 8'hFF;
        endcase
        return {en, mw, ds};
    endfunction

    // ---------------- stimulus ----------------
    task automatic bus_idle();
        cpu_bus.mreq_n = 1'b1;
        cpu_bus.iorq_n = 1'b1;
        cpu_bus.rd_n   = 1'b1;
        cpu_bus.wr_n   = 1'b1;
        cpu_bus.m1_n   = 1'b1;
    endtask

    task automatic bus_strobe(input int k, input logic m1);
        bus_idle();
        case (k)
            K_MEMRD:   begin cpu_bus.mreq_n = 1'b0; cpu_bus.rd_n = 1'b0; cpu_bus.m1_n = m1; end
            K_MEMWR:   begin cpu_bus.mreq_n = 1'b0; cpu_bus.wr_n = 1'b0; end
            K_IORD:    begin cpu_bus.iorq_n = 1'b0; cpu_bus.rd_n = 1'b0; end
            K_IOWR:    begin cpu_bus.iorq_n = 1'b0; cpu_bus.wr_n = 1'b0; end
            K_INTACK:  begin cpu_bus.iorq_n = 1'b0; cpu_bus.m1_n = 1'b0; end
            default:   begin cpu_bus.mreq_n = 1'b0; end
        endcase
    endtask

    task automatic set_slaves_ready(input logic rdy);
        rom_resp.mwait = rdy;
        ram_resp.mwait = rdy;
        io_resp.mwait  = rdy;
    endtask

    function automatic logic [11:0] sample();
        return {rom_ena, ram_ena, io_ena, cpu_resp.mwait, cpu_resp.dslave};
    endfunction

    // Drives one access (strobes low for len cycles, exit cycle at len,
    // optional idle cycle after) and records the outputs of every cycle.
    // All slaves pull mwait low for ext cycles from the hold-start cycle.
    task automatic run_txn(input int k, input logic [15:0] a, input int len, input int ext,
                           input bit scramble, input bit tail);
        int hs, last;
        logic m1;
        hs   = model_hold_start(model_sel(k, a));
        last = tail ? len + 1 : len;
        m1   = 1'($urandom);
        rom_resp.dslave = d_rom;
        ram_resp.dslave = d_ram;
        io_resp.dslave  = d_io;
        for (int c = 0; c <= last; c++) begin
            if (c < len) bus_strobe(k, m1);
            else         bus_idle();
            cpu_bus.addr    = (c == 0 || !scramble) ? a : 16'($urandom);
            cpu_bus.dmaster = 8'($urandom);
            set_slaves_ready(!(c >= hs && c < hs + ext));
            @(negedge clk);
            obs[c] = sample();
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        set_slaves_ready(1'b1);
        repeat (2) @(posedge clk);
        #1;
        bus_strobe(K_MEMRD, 1'b1);
        cpu_bus.addr = 16'h0005;
        @(negedge clk);
        vectors++;
        if (sample() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", sample(), IDLE_VEC);
        end
        @(posedge clk);
        #1;
        bus_idle();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (sample() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", sample(), IDLE_VEC);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rom_read();
        d_rom = 8'h80; d_ram = 8'h11; d_io = 8'h22;
        run_txn(K_MEMRD, 16'h0005, 3, 0, 1'b0, 1'b1);
        for (int c = 0; c <= 4; c++) begin
            vectors++;
            if (obs[c] !== model_vec(S_ROM, c, 3, 0)) begin
                errors++;
                $display("FAIL rom_read cyc%0d: got %h want %h", c, obs[c], model_vec(S_ROM, c, 3, 0));
            end
        end
    endtask

    task automatic test_ram_write();
        d_rom = 8'h33; d_ram = 8'h5A; d_io = 8'h44;
        run_txn(K_MEMWR, 16'h8000, 3, 0, 1'b0, 1'b1);
        for (int c = 0; c <= 4; c++) begin
            vectors++;
            if (obs[c] !== model_vec(S_RAM, c, 3, 0)) begin
                errors++;
                $display("FAIL ram_write cyc%0d: got %h want %h", c, obs[c], model_vec(S_RAM, c, 3, 0));
            end
        end
    endtask

    task automatic test_unmapped();
        d_rom = 8'h01; d_ram = 8'h02; d_io = 8'h03;
        run_txn(K_MEMRD, 16'h7FFF, 2, 0, 1'b0, 1'b1);
        for (int c = 0; c <= 3; c++) begin
            vectors++;
            if (obs[c] !== model_vec(S_NONE, c, 2, 0)) begin
                errors++;
                $display("FAIL unmapped_read cyc%0d: got %h want %h", c, obs[c], model_vec(S_NONE, c, 2, 0));
            end
        end
        run_txn(K_MEMWR, 16'h0010, 2, 0, 1'b0, 1'b1);
        for (int c = 0; c <= 3; c++) begin
            vectors++;
            if (obs[c] !== model_vec(S_NONE, c, 2, 0)) begin
                errors++;
                $display("FAIL rom_write cyc%0d: got %h want %h", c, obs[c], model_vec(S_NONE, c, 2, 0));
            end
        end
    endtask

    task automatic test_intack_refresh();
        d_rom = 8'h10; d_ram = 8'h20; d_io = 8'h30;
        run_txn(K_INTACK, 16'h0000, 2, 0, 1'b0, 1'b1);
        for (int c = 0; c <= 3; c++) begin
            vectors++;
            if (obs[c] !== model_vec(S_INTACK, c, 2, 0)) begin
                errors++;
                $display("FAIL intack cyc%0d: got %h want %h", c, obs[c], model_vec(S_INTACK, c, 2, 0));
            end
        end
        run_txn(K_REFRESH, 16'h0040, 2, 0, 1'b0, 1'b1);
        for (int c = 0; c <= 3; c++) begin
            vectors++;
            if (obs[c] !== IDLE_VEC) begin
                errors++;
                $display("FAIL refresh cyc%0d: got %h want %h", c, obs[c], IDLE_VEC);
            end
        end
    endtask

    task automatic test_io_ext();
        int low;
        d_rom = 8'h0F; d_ram = 8'hF0; d_io = 8'hC3;
        run_txn(K_IORD, 16'h0042, 6, 2, 1'b1, 1'b1);
        low = 0;
        for (int c = 0; c <= 7; c++) begin
            if (obs[c][8] == 1'b0) low++;
            vectors++;
            if (obs[c] !== model_vec(S_IO, c, 6, 2)) begin
                errors++;
                $display("FAIL io_ext cyc%0d: got %h want %h", c, obs[c], model_vec(S_IO, c, 6, 2));
            end
        end
        vectors++;
        if (low != 5) begin
            errors++;
            $display("FAIL io_ext_wait_count: got %0d want 5", low);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] want;
        d_io = 8'h77;
        io_resp.dslave = d_io;
        set_slaves_ready(1'b1);
        bus_strobe(K_IORD, 1'b1);
        cpu_bus.addr = 16'h0003;
        @(negedge clk);
        want = {3'b001, 1'b0, d_io};
        vectors++;
        if (sample() !== want) begin
            errors++;
            $display("FAIL rstmid_start: got %h want %h", sample(), want);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (sample() !== IDLE_VEC) begin
            errors++;
            $display("FAIL rstmid_asserted: got %h want %h", sample(), IDLE_VEC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_idle();
        @(negedge clk);
        vectors++;
        if (sample() !== IDLE_VEC) begin
            errors++;
            $display("FAIL rstmid_after: got %h want %h", sample(), IDLE_VEC);
        end
        @(posedge clk);
        #1;
        d_rom = 8'hA5;
        run_txn(K_MEMRD, 16'h0123, 2, 0, 1'b0, 1'b1);
        for (int c = 0; c <= 3; c++) begin
            vectors++;
            if (obs[c] !== model_vec(S_ROM, c, 2, 0)) begin
                errors++;
                $display("FAIL rstmid_rom cyc%0d: got %h want %h", c, obs[c], model_vec(S_ROM, c, 2, 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        d_rom = 8'h9C; d_ram = 8'h6B; d_io = 8'hE1;
        run_txn(K_MEMRD, 16'h9000, 2, 0, 1'b0, 1'b0);
        for (int c = 0; c <= 2; c++) begin
            vectors++;
            if (obs[c] !== model_vec(S_RAM, c, 2, 0)) begin
                errors++;
                $display("FAIL b2b_ram cyc%0d: got %h want %h", c, obs[c], model_vec(S_RAM, c, 2, 0));
            end
        end
        run_txn(K_MEMRD, 16'h0200, 2, 0, 1'b0, 1'b1);
        for (int c = 0; c <= 3; c++) begin
            vectors++;
            if (obs[c] !== model_vec(S_ROM, c, 2, 0)) begin
                errors++;
                $display("FAIL b2b_rom cyc%0d: got %h want %h", c, obs[c], model_vec(S_ROM, c, 2, 0));
            end
        end
    endtask

    task automatic test_random();
        int k, sel, ext, len, reg_pick;
        logic [15:0] a;
        bit scr, tail;
        for (int t = 0; t < 60; t++) begin
            k        = int'($urandom_range(0, 5));
            reg_pick = int'($urandom_range(0, 3));
            case (reg_pick)
                0:       a = 16'($urandom_range(0, int'(P_ROM_END)));
                1:       a = 16'($urandom_range(int'(P_ROM_END) + 1, int'(P_RAM_BASE) - 1));
                2:       a = 16'($urandom_range(int'(P_RAM_BASE), int'(P_RAM_END)));
                default: a = 16'($urandom);
            endcase
            sel   = model_sel(k, a);
            ext   = int'($urandom_range(0, 2));
            len   = model_hold_start(sel) + ext + int'($urandom_range(0, 2));
            scr   = 1'($urandom);
            tail  = (t == 59) ? 1'b1 : 1'($urandom);
            d_rom = 8'($urandom);
            d_ram = 8'($urandom);
            d_io  = 8'($urandom);
            run_txn(k, a, len, ext, scr, tail);
            for (int c = 0; c <= (tail ? len + 1 : len); c++) begin
                vectors++;
                if (obs[c] !== model_vec(sel, c, len, ext)) begin
                    errors++;
                    $display("FAIL random t%0d kind%0d addr %h cyc%0d: got %h want %h",
                             t, k, a, c, obs[c], model_vec(sel, c, len, ext));
                end
            end
        end
    endtask

    initial begin
        cpu_bus  = '0;
        bus_idle();
        rom_resp = '{dslave: 8'h00, mwait: 1'b1};
        ram_resp = '{dslave: 8'h00, mwait: 1'b1};
        io_resp  = '{dslave: 8'h00, mwait: 1'b1};
        d_rom = 8'h00; d_ram = 8'h00; d_io = 8'h00;
        test_reset();
        test_rom_read();
        test_ram_write();
        test_unmapped();
        test_intack_refresh();
        test_io_ext();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
